// File: rtl/camrst_seq.sv
// Camera power-up sequencer: power-down -> sensor reset -> settle -> ready; optional CAMRST_SEQ_SOFTREQ_EN re-sequence.
// Latency: ready after PWDN_CYC+RST_CYC+READY_CYC edges from the last reset edge; outputs registered.
// No backpressure: soft_req is a pulse that is honoured only in S_READY and is never queued.
module camrst_seq #(
    parameter int PWDN_CYC  = 16,
    parameter int RST_CYC   = 16,
    parameter int READY_CYC = 64,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic soft_req,
    output logic cam_pwdn,
    output logic cam_resetb,
    output logic ready,
    output logic busy
);

    typedef enum logic [1:0] {S_PWDN, S_RST, S_SETTLE, S_READY} state_t;

    localparam logic [CNT_W-1:0] PWDN_LAST  = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwdn_q, resetb_q, ready_q, busy_q;
    logic             soft_go;

`ifdef CAMRST_SEQ_SOFTREQ_EN
    assign soft_go = soft_req;
`else
    logic unused_soft_req;
    assign unused_soft_req = soft_req;
    assign soft_go         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_PWDN: begin
                if (cnt_q == PWDN_LAST) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == READY_LAST) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READY: begin
                cnt_d = '0;
                if (soft_go) begin
                    state_d = S_PWDN;
                end
            end
            default: begin
                state_d = S_PWDN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers load the decode of the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_PWDN;
            cnt_q    <= '0;
            pwdn_q   <= 1'b1;
            resetb_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwdn_q   <= (state_d == S_PWDN);
            resetb_q <= (state_d == S_SETTLE) || (state_d == S_READY);
            ready_q  <= (state_d == S_READY);
            busy_q   <= (state_d != S_READY);
        end
    end

    assign cam_pwdn   = pwdn_q;
    assign cam_resetb = resetb_q;
    assign ready      = ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_camrst_seq.sv
// Bench for camrst_seq: timeline reference model feeds a scoreboard queue; a monitor compares every cycle.
module tb_camrst_seq;

    localparam int P   = 4;
    localparam int R   = 3;
    localparam int S   = 5;
    localparam int TOT = P + R + S;

`ifdef CAMRST_SEQ_SOFTREQ_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    typedef struct packed {
        logic pwdn;
        logic resetb;
        logic rdy;
        logic bsy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic soft_req;
    logic cam_pwdn, cam_resetb, ready, busy;

    int   errors = 0;
    int   checks = 0;
    int   t      = 0;   // edges since the current sequence started, saturating at TOT
    exp_t exp_q[$];

    camrst_seq #(
        .PWDN_CYC (P),
        .RST_CYC  (R),
        .READY_CYC(S),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .soft_req  (soft_req),
        .cam_pwdn  (cam_pwdn),
        .cam_resetb(cam_resetb),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: outputs follow purely from time elapsed since the last restart.
    always @(posedge clk) begin
        exp_t e;
        if (reset)
            t = 0;
        else if (SOFT_EN && soft_req && t >= TOT)
            t = 0;
        else if (t < TOT)
            t = t + 1;
        e.pwdn   = (t < P);
        e.resetb = (t >= P + R);
        e.rdy    = (t >= TOT);
        e.bsy    = (t < TOT);
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            chk("cam_pwdn", cam_pwdn, e.pwdn);
            chk("cam_resetb", cam_resetb, e.resetb);
            chk("ready", ready, e.rdy);
            chk("busy", busy, e.bsy);
            chk("no_resetb_while_pwdn", cam_resetb & cam_pwdn, 1'b0);
        end
    end

    task automatic step(input logic r, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = r;
            soft_req = s;
        end
    endtask

    initial begin
        reset    = 1'b1;
        soft_req = 1'b0;
        // Reset held for 10 edges, then a full sequence with a soft_req during S_RST.
        step(1, 0, 10);
        step(0, 0, 4);
        step(0, 1, 1);
        step(0, 0, 15);
        // Soft re-sequence from S_READY, then a full run.
        step(0, 1, 1);
        step(0, 0, 16);
        // One-cycle reset in the middle of S_SETTLE.
        step(1, 0, 1);
        step(0, 0, 9);
        step(1, 0, 1);
        step(0, 0, 16);
        // reset and soft_req together in S_READY.
        step(1, 1, 1);
        step(0, 0, 16);
        // Randomized reset and soft_req pulses.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), 1);
        end
        step(0, 0, 3);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
